// File: rtl/lm75a_poll_ctrl.sv
// lm75a_poll_ctrl: periodic I2C read of the LM75A temperature
// register, presented as {MSB, LSB} with a one-cycle valid strobe.
`timescale 1ns/1ps
module lm75a_poll_ctrl #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned I2C_HZ      = 100_000,
  parameter int unsigned POLL_CYCLES = 12_500_000,
  parameter logic [6:0]  DEV_ADDR    = 7'h48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic [15:0] temp_data,
  output logic        data_valid,
  output logic        ack_err,
  output logic        busy
);

  localparam int unsigned QTR = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int unsigned PW  =
    (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [QW-1:0] Q_LAST  = QW'(QTR - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [7:0]    ADDR_RD = {DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_RD_MSB,
    S_MACK,
    S_RD_LSB,
    S_MNACK,
    S_STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    q;
  logic [1:0]    q_n;
  logic [2:0]    bcnt;
  logic [2:0]    bcnt_n;
  logic [QW-1:0] qcnt;
  logic [PW-1:0] pcnt;
  logic [15:0]   sreg;
  logic          abort;

  logic active;
  logic stall;
  logic tick;
  logic sample;
  logic done;
  logic launch;
  logic shift_en;

  // Open-drain levels for a given phase: {scl low, sda low}.
  // Data bits change SDA in q0 with SCL low; SCL high in q1..q2.
  function automatic logic [1:0] bus_drive(
    input state_t     st,
    input logic [1:0] qq,
    input logic [2:0] bb
  );
    logic scl_l;
    logic sda_l;
    scl_l = (qq == 2'd0) || (qq == 2'd3);
    sda_l = 1'b0;
    unique case (st)
      S_IDLE: scl_l = 1'b0;
      S_START: begin
        scl_l = (qq == 2'd3);
        sda_l = (qq != 2'd0);
      end
      S_ADDR:  sda_l = !ADDR_RD[bb];
      S_MACK:  sda_l = 1'b1;
      S_STOP: begin
        scl_l = (qq == 2'd0);
        sda_l = !qq[1];
      end
      default: sda_l = 1'b0;
    endcase
    return {scl_l, sda_l};
  endfunction

  assign active   = (state != S_IDLE);
  assign stall    = active && (q == 2'd1) && !scl_in;
  assign tick     = active && (qcnt == Q_LAST) && !stall;
  assign sample   = tick && (q == 2'd2);
  assign done     = tick && (q == 2'd3) && (state == S_STOP);
  assign launch   = !active && en && (pcnt == P_LAST);
  assign shift_en = sample &&
    ((state == S_RD_MSB) || (state == S_RD_LSB));

  // Next phase / bit / state, advancing only on a quarter tick.
  always_comb begin
    state_n = state;
    q_n     = q;
    bcnt_n  = bcnt;
    if (launch) begin
      state_n = S_START;
      q_n     = 2'd0;
      bcnt_n  = 3'd7;
    end else if (tick) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        unique case (state)
          S_START: state_n = S_ADDR;
          S_ADDR: begin
            bcnt_n = bcnt - 3'd1;
            if (bcnt == 3'd0) state_n = S_AACK;
          end
          S_AACK: begin
            bcnt_n  = 3'd7;
            state_n = abort ? S_STOP : S_RD_MSB;
          end
          S_RD_MSB: begin
            bcnt_n = bcnt - 3'd1;
            if (bcnt == 3'd0) state_n = S_MACK;
          end
          S_MACK: begin
            bcnt_n  = 3'd7;
            state_n = S_RD_LSB;
          end
          S_RD_LSB: begin
            bcnt_n = bcnt - 3'd1;
            if (bcnt == 3'd0) state_n = S_MNACK;
          end
          S_MNACK: state_n = S_STOP;
          S_STOP:  state_n = S_IDLE;
          default: state_n = S_IDLE;
        endcase
      end
    end
  end

  // State, phase, bus pins and busy move together on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      q      <= 2'd0;
      bcnt   <= 3'd7;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      bcnt   <= bcnt_n;
      {scl_oe, sda_oe} <= bus_drive(state_n, q_n, bcnt_n);
      busy   <= (state_n != S_IDLE);
    end
  end

  // Quarter-bit divider; frozen while a slave stretches SCL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
    end else if (!active || tick) begin
      qcnt <= '0;
    end else if (!stall) begin
      qcnt <= qcnt + QW'(1);
    end
  end

  // Poll interval counter; only runs while idle and enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (active || !en || launch) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Read data capture, abort tracking and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      abort      <= 1'b0;
      ack_err    <= 1'b0;
      temp_data  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= done && !abort;
      if (launch) begin
        sreg  <= '0;
        abort <= 1'b0;
      end
      if (sample && (state == S_AACK) && sda_in) begin
        abort   <= 1'b1;
        ack_err <= 1'b1;
      end
      if (shift_en) begin
        sreg <= {sreg[14:0], sda_in};
      end
      if (done && !abort) begin
        temp_data <= sreg;
        ack_err   <= 1'b0;
      end
    end
  end

endmodule
